lcd_spi_responder: RTL and testbench

//  Display-side end of the PCD8544 (84x48 Nokia LCD) SPI link that spi_master drives.

---
 rtl/lcd_spi_responder_pkg.sv | 62 ++++++
 rtl/lcd_spi_responder_if.sv | 13 +
 rtl/lcd_spi_responder_spi_rx_shift.sv | 88 ++++++++
 rtl/lcd_spi_responder.sv | 143 ++++++++++++++
 tb/tb_lcd_spi_responder.sv | 265 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/lcd_spi_responder_pkg.sv
// PCD8544 display-model constants: geometry defaults, command opcode
// mask/value pairs, register reset values and small decode helpers.
// No ports; imported by the responder, its receiver and nothing else.
package lcd_spi_responder_pkg;

  localparam int SYNC_STAGES_DEF = 2;
  localparam int COLS_DEF        = 84;
  localparam int ROWS_DEF        = 6;

  // Command opcodes as (mask, value): a byte matches when (byte & mask) == value.
  localparam logic [7:0] OP_NOP  = 8'h00;
  localparam logic [7:0] M_FUNC  = 8'hF8;  localparam logic [7:0] V_FUNC = 8'h20;
  localparam logic [7:0] M_DISP  = 8'hFA;  localparam logic [7:0] V_DISP = 8'h08;
  localparam logic [7:0] M_SET_Y = 8'hF8;  localparam logic [7:0] V_SET_Y = 8'h40;
  localparam logic [7:0] M_SET_X = 8'h80;  localparam logic [7:0] V_SET_X = 8'h80;
  localparam logic [7:0] M_TC    = 8'hFC;  localparam logic [7:0] V_TC    = 8'h04;
  localparam logic [7:0] M_BIAS  = 8'hF8;  localparam logic [7:0] V_BIAS  = 8'h10;
  localparam logic [7:0] M_VOP   = 8'h80;  localparam logic [7:0] V_VOP   = 8'h80;

  // Controller register reset values (power-down asserted, everything else clear).
  localparam logic       PD_RST   = 1'b1;
  localparam logic [1:0] DISP_RST = 2'b00;
  localparam logic [6:0] VOP_RST  = 7'd0;
  localparam logic [2:0] BIAS_RST = 3'd0;
  localparam logic [1:0] TC_RST   = 2'd0;

  typedef enum logic [3:0] {
    CMD_NONE,
    CMD_NOP,
    CMD_FUNC,
    CMD_DISP,
    CMD_SET_Y,
    CMD_SET_X,
    CMD_TC,
    CMD_BIAS,
    CMD_VOP
  } cmd_e;

  // Function set is legal in both instruction pages; the rest depend on H.
  function automatic cmd_e decode_cmd(logic [7:0] b, logic h);
    cmd_e c;
    c = CMD_NONE;
    if (b == OP_NOP)                        c = CMD_NOP;
    else if ((b & M_FUNC) == V_FUNC)        c = CMD_FUNC;
    else if (!h) begin
      if ((b & M_DISP) == V_DISP)           c = CMD_DISP;
      else if ((b & M_SET_Y) == V_SET_Y)    c = CMD_SET_Y;
      else if ((b & M_SET_X) == V_SET_X)    c = CMD_SET_X;
    end else begin
      if ((b & M_TC) == V_TC)               c = CMD_TC;
      else if ((b & M_BIAS) == V_BIAS)      c = CMD_BIAS;
      else if ((b & M_VOP) == V_VOP)        c = CMD_VOP;
    end
    return c;
  endfunction

  // Linear frame-buffer index, banks laid out one after another.
  function automatic logic [8:0] fb_index(logic [2:0] y, logic [6:0] x, int cols);
    return 9'(int'(y) * cols + int'(x));
  endfunction

endpackage

// File: rtl/lcd_spi_responder_if.sv
// LCD-side SPI pin bundle: sclk, sce (active-low), mosi, dc, lcd_rst (active-low).
// master modport drives the pins (SPI master / bench), slave modport observes them.
// Pins are asynchronous to the receiver clock; no handshake, no backpressure.
interface lcd_spi_responder_if;
  logic sclk;
  logic sce;
  logic mosi;
  logic dc;
  logic lcd_rst;

  modport master (output sclk, sce, mosi, dc, lcd_rst);
  modport slave  (input  sclk, sce, mosi, dc, lcd_rst);
endinterface

// File: rtl/lcd_spi_responder_spi_rx_shift.sv
// SPI byte receiver: synchronizes the pins, detects sclk rises, shifts MSB-first bytes.
// Latency: byte_valid SYNC_STAGES+1 clk after the 8th sclk pin rise; no backpressure.
// Ports: clk/reset, spi (slave pins) in; byte_valid/byte_out/byte_dc, frame_err, lcd_in_reset out.
// With LCD_RESP_FRAME_CHECK_EN defined, sce rising mid-byte pulses frame_err; else frame_err=0.
module lcd_spi_responder_spi_rx_shift
  import lcd_spi_responder_pkg::*;
#(
  parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
  input  logic                      clk,
  input  logic                      reset,
  lcd_spi_responder_if.slave        spi,
  output logic                      byte_valid,
  output logic [7:0]                byte_out,
  output logic                      byte_dc,
  output logic                      frame_err,
  output logic                      lcd_in_reset
);

  // Pin vector order {lcd_rst, dc, mosi, sce, sclk}; the idle-high pins reset to 1.
  localparam logic [4:0] SYNC_RST = 5'b10010;

  logic [SYNC_STAGES-1:0][4:0] sync_q;
  logic [4:0] pins_s;
  logic       sclk_s, sce_s, mosi_s, dc_s, lcd_rst_s;
  logic       sclk_prev;
  logic       sclk_rise;
  logic [6:0] shift_q;
  logic [2:0] bit_cnt;

  assign pins_s       = sync_q[SYNC_STAGES-1];
  assign sclk_s       = pins_s[0];
  assign sce_s        = pins_s[1];
  assign mosi_s       = pins_s[2];
  assign dc_s         = pins_s[3];
  assign lcd_rst_s    = pins_s[4];
  assign sclk_rise    = sclk_s & ~sclk_prev;
  assign lcd_in_reset = ~lcd_rst_s;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q     <= {SYNC_STAGES{SYNC_RST}};
      sclk_prev  <= 1'b0;
      shift_q    <= '0;
      bit_cnt    <= '0;
      byte_valid <= 1'b0;
      byte_out   <= '0;
      byte_dc    <= 1'b0;
    end else begin
      sync_q     <= {sync_q[SYNC_STAGES-2:0],
                     {spi.lcd_rst, spi.dc, spi.mosi, spi.sce, spi.sclk}};
      // Edge history keeps tracking during LCD reset so release never fakes a rise.
      sclk_prev  <= sclk_s;
      byte_valid <= 1'b0;
      if (!lcd_rst_s) begin
        shift_q  <= '0;
        bit_cnt  <= '0;
        byte_out <= '0;
        byte_dc  <= 1'b0;
      end else if (sce_s) begin
        // Deselect abandons any partial byte; stale shifter bits are pushed
        // out by the next eight accepted bits.
        bit_cnt <= '0;
      end else if (sclk_rise) begin
        shift_q <= {shift_q[5:0], mosi_s};
        if (bit_cnt == 3'd7) begin
          bit_cnt    <= '0;
          byte_valid <= 1'b1;
          byte_out   <= {shift_q, mosi_s};
          byte_dc    <= dc_s;
        end else begin
          bit_cnt <= bit_cnt + 3'd1;
        end
      end
    end
  end

`ifdef LCD_RESP_FRAME_CHECK_EN
  // A non-zero count can only be seen with sce high on the first deselected cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) frame_err <= 1'b0;
    else       frame_err <= lcd_rst_s & sce_s & (bit_cnt != 3'd0);
  end
`else
  assign frame_err = 1'b0;
`endif

endmodule

// File: rtl/lcd_spi_responder.sv
// PCD8544 display model: decodes SPI command bytes into controller registers and stores
// data bytes in an 84x6-byte frame buffer. Latency: regs/RAM update 1 clk after byte_valid;
// rd_data 1 clk after rd_addr. No backpressure: every completed byte is consumed.
// Ports: clk, reset, spi (slave pins) in; byte strobe/value, pd/v_mode/h_set, disp_mode,
// vop, bias, tc, cur_x/cur_y, addr_err, frame_err out; rd_addr in / rd_data out.
// Optional macro LCD_RESP_FRAME_CHECK_EN enables frame_err (mid-byte deselect detect).
module lcd_spi_responder
  import lcd_spi_responder_pkg::*;
#(
  parameter int SYNC_STAGES = SYNC_STAGES_DEF,
  parameter int COLS        = COLS_DEF,
  parameter int ROWS        = ROWS_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  lcd_spi_responder_if.slave   spi,
  output logic                 byte_valid,
  output logic [7:0]           byte_out,
  output logic                 byte_dc,
  output logic                 pd,
  output logic                 v_mode,
  output logic                 h_set,
  output logic [1:0]           disp_mode,
  output logic [6:0]           vop,
  output logic [2:0]           bias,
  output logic [1:0]           tc,
  output logic [6:0]           cur_x,
  output logic [2:0]           cur_y,
  output logic                 addr_err,
  input  logic [8:0]           rd_addr,
  output logic [7:0]           rd_data,
  output logic                 frame_err
);

  localparam logic [7:0] COLS_W = 8'(COLS);
  localparam logic [3:0] ROWS_W = 4'(ROWS);
  localparam logic [6:0] LAST_X = 7'(COLS - 1);
  localparam logic [2:0] LAST_Y = 3'(ROWS - 1);

  logic       lcd_in_reset;
  cmd_e       cmd;
  logic       ram_we;
  logic [8:0] wr_idx;
  logic [7:0] ram [COLS*ROWS];

  lcd_spi_responder_spi_rx_shift #(.SYNC_STAGES(SYNC_STAGES)) u_rx (
    .clk          (clk),
    .reset        (reset),
    .spi          (spi),
    .byte_valid   (byte_valid),
    .byte_out     (byte_out),
    .byte_dc      (byte_dc),
    .frame_err    (frame_err),
    .lcd_in_reset (lcd_in_reset)
  );

  always_comb begin
    cmd = CMD_NONE;
    if (byte_valid && !byte_dc) cmd = decode_cmd(byte_out, h_set);
  end

  assign ram_we = byte_valid & byte_dc;
  assign wr_idx = fb_index(cur_y, cur_x, COLS);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pd        <= PD_RST;
      v_mode    <= 1'b0;
      h_set     <= 1'b0;
      disp_mode <= DISP_RST;
      vop       <= VOP_RST;
      bias      <= BIAS_RST;
      tc        <= TC_RST;
      cur_x     <= '0;
      cur_y     <= '0;
      addr_err  <= 1'b0;
    end else if (lcd_in_reset) begin
      pd        <= PD_RST;
      v_mode    <= 1'b0;
      h_set     <= 1'b0;
      disp_mode <= DISP_RST;
      vop       <= VOP_RST;
      bias      <= BIAS_RST;
      tc        <= TC_RST;
      cur_x     <= '0;
      cur_y     <= '0;
      addr_err  <= 1'b0;
    end else begin
      addr_err <= 1'b0;
      // Address auto-advance after a data write; both modes wrap to (0,0).
      if (ram_we) begin
        if (!v_mode) begin
          if (cur_x == LAST_X) begin
            cur_x <= '0;
            cur_y <= (cur_y == LAST_Y) ? 3'd0 : cur_y + 3'd1;
          end else begin
            cur_x <= cur_x + 7'd1;
          end
        end else begin
          if (cur_y == LAST_Y) begin
            cur_y <= '0;
            cur_x <= (cur_x == LAST_X) ? 7'd0 : cur_x + 7'd1;
          end else begin
            cur_y <= cur_y + 3'd1;
          end
        end
      end
      case (cmd)
        CMD_FUNC: begin
          pd     <= byte_out[2];
          v_mode <= byte_out[1];
          h_set  <= byte_out[0];
        end
        CMD_DISP: disp_mode <= {byte_out[2], byte_out[0]};
        CMD_SET_Y: begin
          if ({1'b0, byte_out[2:0]} < ROWS_W) cur_y <= byte_out[2:0];
          else                                addr_err <= 1'b1;
        end
        CMD_SET_X: begin
          if ({1'b0, byte_out[6:0]} < COLS_W) cur_x <= byte_out[6:0];
          else                                addr_err <= 1'b1;
        end
        CMD_TC:   tc   <= byte_out[1:0];
        CMD_BIAS: bias <= byte_out[2:0];
        CMD_VOP:  vop  <= byte_out[6:0];
        default: ;
      endcase
    end
  end

  // Frame buffer has no reset: contents survive both reset sources.
  always_ff @(posedge clk) begin
    if (ram_we) ram[wr_idx] <= byte_out;
  end

  // Read-before-write: a same-cycle read of the written address returns old data.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)             rd_data <= '0;
    else if (lcd_in_reset) rd_data <= '0;
    else                   rd_data <= ram[rd_addr];
  end

endmodule

// File: tb/tb_lcd_spi_responder.sv
`timescale 1ns/1ps
module tb_lcd_spi_responder;

`ifdef LCD_RESP_FRAME_CHECK_EN
  localparam int FRAME_ERR_EXP = 1;
`else
  localparam int FRAME_ERR_EXP = 0;
`endif

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  lcd_spi_responder_if spi();

  logic       byte_valid, byte_dc, pd, v_mode, h_set, addr_err, frame_err;
  logic [7:0] byte_out, rd_data;
  logic [1:0] disp_mode, tc;
  logic [6:0] vop, cur_x;
  logic [2:0] bias, cur_y;
  logic [8:0] rd_addr;

  lcd_spi_responder dut (
    .clk(clk), .reset(reset), .spi(spi),
    .byte_valid(byte_valid), .byte_out(byte_out), .byte_dc(byte_dc),
    .pd(pd), .v_mode(v_mode), .h_set(h_set), .disp_mode(disp_mode),
    .vop(vop), .bias(bias), .tc(tc), .cur_x(cur_x), .cur_y(cur_y),
    .addr_err(addr_err), .rd_addr(rd_addr), .rd_data(rd_data), .frame_err(frame_err)
  );

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int edge_cyc = 0;
  int addr_err_cnt = 0;
  int frame_err_cnt = 0;
  int e0, f0;
  logic [8:0] exp_q[$];
  logic       probe_en = 1'b0;
  int         probe_stage = 0;
  logic [7:0] rw_old, rw_new;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Output monitor: scoreboard for completed bytes plus strobe counters.
  always @(negedge clk) begin
    logic [8:0] e;
    if (addr_err)  addr_err_cnt++;
    if (frame_err) frame_err_cnt++;
    if (byte_valid) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $error("FAIL byte_unexpected: observed %0h, expected no byte", {byte_dc, byte_out});
      end else begin
        e = exp_q.pop_front();
        check("byte", {23'd0, byte_dc, byte_out}, {23'd0, e});
        check("byte_latency", cyc - edge_cyc, 3);
      end
    end
  end

  // Captures rd_data on the two cycles after a data byte strobe (old, then new).
  always @(negedge clk) begin
    if (probe_stage == 1) begin
      rw_old = rd_data;
      probe_stage = 2;
    end else if (probe_stage == 2) begin
      rw_new = rd_data;
      probe_stage = 3;
    end
    if (probe_en && byte_valid && byte_dc && probe_stage == 0) probe_stage = 1;
  end

  task automatic send_bits(input logic d, input logic [7:0] b, input int nbits);
    @(negedge clk);
    spi.sce = 1'b0;
    spi.dc  = d;
    for (int i = 7; i > 7 - nbits; i--) begin
      spi.mosi = b[i];
      repeat (4) @(negedge clk);
      spi.sclk = 1'b1;
      edge_cyc = cyc;
      repeat (4) @(negedge clk);
      spi.sclk = 1'b0;
    end
  endtask

  task automatic send_byte(input logic d, input logic [7:0] b);
    exp_q.push_back({d, b});
    send_bits(d, b, 8);
    repeat (4) @(negedge clk);
    spi.sce = 1'b1;
    repeat (6) @(negedge clk);
  endtask

  task automatic read_ram(input string tag, input logic [8:0] a, input logic [7:0] exp);
    @(negedge clk);
    rd_addr = a;
    @(negedge clk);
    check(tag, rd_data, exp);
  endtask

  initial begin
    #400000;
    n_err++;
    $display("FAIL watchdog: observed no end of test, expected finish before 400us");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1;
    spi.sclk = 1'b0; spi.sce = 1'b1; spi.mosi = 1'b0; spi.dc = 1'b0; spi.lcd_rst = 1'b1;
    rd_addr = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (4) @(negedge clk);

    // Reset state
    check("rst_pd", pd, 1);
    check("rst_vh", {v_mode, h_set}, 0);
    check("rst_vop", vop, 0);
    check("rst_disp", disp_mode, 0);
    check("rst_bias_tc", {bias, tc}, 0);
    check("rst_xy", {cur_x, cur_y}, 0);
    check("rst_strobes", {byte_valid, addr_err, frame_err}, 0);
    check("rst_byte", {byte_dc, byte_out}, 0);

    // Basic configuration
    send_byte(1'b0, 8'h21);
    send_byte(1'b0, 8'h90);
    send_byte(1'b0, 8'h20);
    send_byte(1'b0, 8'h0C);
    check("cfg_pd", pd, 0);
    check("cfg_h", h_set, 0);
    check("cfg_vop", vop, 7'h10);
    check("cfg_disp", disp_mode, 2'b10);

    // Horizontal writes
    send_byte(1'b0, 8'h80 + 8'd10);
    send_byte(1'b0, 8'h42);
    send_byte(1'b1, 8'hAA);
    send_byte(1'b1, 8'h55);
    check("h_cur_x", cur_x, 12);
    check("h_cur_y", cur_y, 2);
    read_ram("ram178", 9'd178, 8'hAA);
    read_ram("ram179", 9'd179, 8'h55);

    // Horizontal wrap at last cell
    send_byte(1'b0, 8'hD3);
    send_byte(1'b0, 8'h45);
    send_byte(1'b1, 8'h11);
    send_byte(1'b1, 8'h22);
    check("hwrap_cur", {cur_x, cur_y}, {7'd1, 3'd0});
    read_ram("ram503", 9'd503, 8'h11);
    read_ram("ram0", 9'd0, 8'h22);

    // Vertical addressing wrap
    send_byte(1'b0, 8'h22);
    send_byte(1'b0, 8'h80);
    send_byte(1'b0, 8'h45);
    send_byte(1'b1, 8'h33);
    send_byte(1'b1, 8'h44);
    check("v_mode", v_mode, 1);
    check("vwrap_cur", {cur_x, cur_y}, {7'd1, 3'd1});
    read_ram("ram420", 9'd420, 8'h33);
    read_ram("ram1", 9'd1, 8'h44);

    // Out-of-range addresses
    e0 = addr_err_cnt;
    send_byte(1'b0, 8'hD4);
    check("x84_keep", cur_x, 1);
    send_byte(1'b0, 8'h47);
    check("y7_keep", cur_y, 1);
    send_byte(1'b0, 8'h46);
    check("y6_keep", cur_y, 1);
    check("addr_err_pulses", addr_err_cnt - e0, 3);
    send_byte(1'b0, 8'hD3);
    check("x83_ok", cur_x, 83);
    check("x83_no_err", addr_err_cnt - e0, 3);

    // Extended instruction page
    send_byte(1'b0, 8'h21);
    send_byte(1'b0, 8'h06);
    send_byte(1'b0, 8'h13);
    send_byte(1'b0, 8'hBF);
    send_byte(1'b0, 8'h0C);
    check("ext_tc", tc, 2);
    check("ext_bias", bias, 3);
    check("ext_vop", vop, 7'h3F);
    check("ext_disp_ignored", disp_mode, 2'b10);
    check("ext_x_untouched", cur_x, 83);
    send_byte(1'b0, 8'h22);

    // Same-cycle read/write returns old data
    send_byte(1'b0, 8'h8A);
    send_byte(1'b0, 8'h42);
    @(negedge clk);
    rd_addr = 9'd178;
    probe_en = 1'b1;
    send_byte(1'b1, 8'h5A);
    probe_en = 1'b0;
    check("rw_probe_done", probe_stage, 3);
    check("rw_old", rw_old, 8'hAA);
    check("rw_new", rw_new, 8'h5A);
    check("rw_cur", {cur_x, cur_y}, {7'd10, 3'd3});

    // Partial byte then full byte
    f0 = frame_err_cnt;
    send_bits(1'b1, 8'hFF, 5);
    repeat (4) @(negedge clk);
    spi.sce = 1'b1;
    repeat (8) @(negedge clk);
    check("frame_err_pulse", frame_err_cnt - f0, FRAME_ERR_EXP);
    send_byte(1'b1, 8'hF0);
    check("frame_byte", byte_out, 8'hF0);
    read_ram("ram262", 9'd262, 8'hF0);

    // LCD reset mid-byte, sclk edges ignored while held
    send_bits(1'b0, 8'hFF, 3);
    @(negedge clk);
    spi.lcd_rst = 1'b0;
    repeat (4) @(negedge clk);
    check("lrst_pd_low", pd, 1);
    for (int k = 0; k < 3; k++) begin
      spi.sclk = 1'b1;
      repeat (4) @(negedge clk);
      spi.sclk = 1'b0;
      repeat (4) @(negedge clk);
    end
    spi.lcd_rst = 1'b1;
    repeat (4) @(negedge clk);
    spi.sce = 1'b1;
    repeat (6) @(negedge clk);
    check("lrst_pd", pd, 1);
    check("lrst_vop", vop, 0);
    check("lrst_bias_tc", {bias, tc}, 0);
    check("lrst_disp", disp_mode, 0);
    check("lrst_vh", {v_mode, h_set}, 0);
    check("lrst_xy", {cur_x, cur_y}, 0);
    check("lrst_byte", byte_out, 0);
    send_byte(1'b0, 8'h21);
    send_byte(1'b0, 8'hC5);
    check("post_vop", vop, 7'h45);
    check("post_pd_h", {pd, h_set}, 2'b01);
    read_ram("ram262_kept", 9'd262, 8'hF0);

    for (int k = 0; k < 20 && exp_q.size() != 0; k++) @(negedge clk);
    check("queue_drained", exp_q.size(), 0);
    check("frame_err_total", frame_err_cnt, FRAME_ERR_EXP);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
